// File: rtl/bp_me_pkg.sv
// Shared BP memory-endpoint definitions used by the host stream to AXI4-Lite
// master path: FSM state encoding, command beat layout and AXI response codes.
package bp_me_pkg;

  typedef enum logic [2:0] {
    e_addr,
    e_data,
    e_write,
    e_bresp,
    e_read,
    e_rdata,
    e_resp
  } bp_stream_axil_state_e;

  // Bit of the address beat that selects write (1) or read (0)
  localparam int unsigned stream_wr_flag_bit_gp = 0;

  // AXI response encodings
  localparam logic [1:0] axil_resp_okay_gp   = 2'b00;
  localparam logic [1:0] axil_resp_slverr_gp = 2'b10;

endpackage

// File: rtl/bp_stream_axil_master_if.sv
// Bundle of the host command stream, the response stream and the AXI4-Lite
// master channels. The master modport is the bridge's view; slave is the
// view of whatever surrounds it (host endpoint plus BP AXI-Lite slave).
interface bp_stream_axil_master_if #(
  parameter int stream_addr_width_p = 32,
  parameter int stream_data_width_p = 32
);

  logic                           stream_v_i;
  logic [stream_data_width_p-1:0] stream_data_i;
  logic                           stream_ready_o;

  logic                           stream_v_o;
  logic [stream_data_width_p-1:0] stream_data_o;
  logic                           stream_ready_i;

  logic [stream_addr_width_p-1:0] m_axil_awaddr_o;
  logic [2:0]                     m_axil_awprot_o;
  logic                           m_axil_awvalid_o;
  logic                           m_axil_awready_i;

  logic [stream_data_width_p-1:0] m_axil_wdata_o;
  logic [3:0]                     m_axil_wstrb_o;
  logic                           m_axil_wvalid_o;
  logic                           m_axil_wready_i;

  logic [1:0]                     m_axil_bresp_i;
  logic                           m_axil_bvalid_i;
  logic                           m_axil_bready_o;

  logic [stream_addr_width_p-1:0] m_axil_araddr_o;
  logic [2:0]                     m_axil_arprot_o;
  logic                           m_axil_arvalid_o;
  logic                           m_axil_arready_i;

  logic [stream_data_width_p-1:0] m_axil_rdata_i;
  logic [1:0]                     m_axil_rresp_i;
  logic                           m_axil_rvalid_i;
  logic                           m_axil_rready_o;

  modport master (
    input  stream_v_i, stream_data_i, output stream_ready_o,
    output stream_v_o, stream_data_o, input  stream_ready_i,
    output m_axil_awaddr_o, m_axil_awprot_o, m_axil_awvalid_o, input m_axil_awready_i,
    output m_axil_wdata_o, m_axil_wstrb_o, m_axil_wvalid_o, input m_axil_wready_i,
    input  m_axil_bresp_i, m_axil_bvalid_i, output m_axil_bready_o,
    output m_axil_araddr_o, m_axil_arprot_o, m_axil_arvalid_o, input m_axil_arready_i,
    input  m_axil_rdata_i, m_axil_rresp_i, m_axil_rvalid_i, output m_axil_rready_o
  );

  modport slave (
    output stream_v_i, stream_data_i, input  stream_ready_o,
    input  stream_v_o, stream_data_o, output stream_ready_i,
    input  m_axil_awaddr_o, m_axil_awprot_o, m_axil_awvalid_o, output m_axil_awready_i,
    input  m_axil_wdata_o, m_axil_wstrb_o, m_axil_wvalid_o, output m_axil_wready_i,
    output m_axil_bresp_i, m_axil_bvalid_i, input  m_axil_bready_o,
    input  m_axil_araddr_o, m_axil_arprot_o, m_axil_arvalid_o, output m_axil_arready_i,
    output m_axil_rdata_i, m_axil_rresp_i, m_axil_rvalid_i, input  m_axil_rready_o
  );

endinterface

// File: rtl/bp_stream_async_reg.sv
// Width-parameterised load-enable register, cleared by the asynchronous
// active-low reset. Holds the command address, data and response words.
module bp_stream_async_reg #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               en_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  // Load on enable, clear on reset
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) data_o <= '0;
    else if (en_i)  data_o <= data_i;
  end

endmodule

// File: rtl/bp_stream_axil_master.sv
// Host word stream to AXI4-Lite master bridge. Each host command is an
// address beat (bit 0 = write flag) followed by a data beat; exactly one AXI
// transaction is in flight at a time. Read data goes back on the response
// stream. Optional feature macro BP_STREAM_AXIL_WRITE_ACK_EN: when defined,
// every write also returns one response word {30'b0, bresp}.
module bp_stream_axil_master
  import bp_me_pkg::*;
#(
  parameter int stream_addr_width_p = 32,
  parameter int stream_data_width_p = 32
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  bp_stream_axil_master_if.master      bus
);

  bp_stream_axil_state_e state_r, state_n;

  logic aw_done_r, w_done_r, aw_done_n, w_done_n;
  logic aw_hs, w_hs;
  logic addr_en, data_en, resp_en;
  logic wr_r;
  logic [stream_addr_width_p-1:0] addr_r, addr_d;
  logic [stream_data_width_p-1:0] data_r, resp_r, resp_d;
  logic unused_bits;

  // The AXI address is word aligned; the reserved bit and rresp carry nothing
  assign addr_d      = {bus.stream_data_i[stream_addr_width_p-1:2], 2'b00};
  assign unused_bits = ^{bus.stream_data_i[1], bus.m_axil_rresp_i, bus.m_axil_bresp_i};

  // Moore decodes of state and done flags
  assign bus.stream_ready_o   = (state_r == e_addr) || (state_r == e_data);
  assign bus.m_axil_awvalid_o = (state_r == e_write) && !aw_done_r;
  assign bus.m_axil_wvalid_o  = (state_r == e_write) && !w_done_r;
  assign bus.m_axil_bready_o  = (state_r == e_bresp);
  assign bus.m_axil_arvalid_o = (state_r == e_read);
  assign bus.m_axil_rready_o  = (state_r == e_rdata);
  assign bus.stream_v_o       = (state_r == e_resp);

  assign bus.stream_data_o   = resp_r;
  assign bus.m_axil_awaddr_o = addr_r;
  assign bus.m_axil_araddr_o = addr_r;
  assign bus.m_axil_wdata_o  = data_r;
  assign bus.m_axil_awprot_o = 3'b000;
  assign bus.m_axil_arprot_o = 3'b000;
  assign bus.m_axil_wstrb_o  = 4'hF;

  assign aw_hs = bus.m_axil_awvalid_o && bus.m_axil_awready_i;
  assign w_hs  = bus.m_axil_wvalid_o  && bus.m_axil_wready_i;

  // Next-state, done-flag tracking and capture enables
  always_comb begin
    state_n   = state_r;
    aw_done_n = aw_done_r;
    w_done_n  = w_done_r;
    addr_en   = 1'b0;
    data_en   = 1'b0;
    resp_en   = 1'b0;
    resp_d    = '0;
    case (state_r)
      e_addr: if (bus.stream_v_i) begin
        addr_en = 1'b1;
        state_n = e_data;
      end
      e_data: if (bus.stream_v_i) begin
        data_en = 1'b1;
        state_n = wr_r ? e_write : e_read;
      end
      e_write: begin
        // AW and W retire independently; leave once both have been accepted
        aw_done_n = aw_done_r || aw_hs;
        w_done_n  = w_done_r  || w_hs;
        if (aw_done_n && w_done_n) begin
          aw_done_n = 1'b0;
          w_done_n  = 1'b0;
          state_n   = e_bresp;
        end
      end
      e_bresp: if (bus.m_axil_bvalid_i) begin
`ifdef BP_STREAM_AXIL_WRITE_ACK_EN
        resp_en = 1'b1;
        resp_d  = {{(stream_data_width_p-2){1'b0}}, bus.m_axil_bresp_i};
        state_n = e_resp;
`else
        state_n = e_addr;
`endif
      end
      e_read:  if (bus.m_axil_arready_i) state_n = e_rdata;
      e_rdata: if (bus.m_axil_rvalid_i) begin
        resp_en = 1'b1;
        resp_d  = bus.m_axil_rdata_i;
        state_n = e_resp;
      end
      e_resp:  if (bus.stream_ready_i) state_n = e_addr;
      default: state_n = e_addr;
    endcase
  end

  // State and done-flag registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= e_addr;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      state_r   <= state_n;
      aw_done_r <= aw_done_n;
      w_done_r  <= w_done_n;
    end
  end

  bp_stream_async_reg #(.width_p(stream_addr_width_p)) addr_reg (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .en_i(addr_en), .data_i(addr_d), .data_o(addr_r)
  );

  bp_stream_async_reg #(.width_p(1)) wr_reg (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .en_i(addr_en),
    .data_i(bus.stream_data_i[stream_wr_flag_bit_gp]), .data_o(wr_r)
  );

  bp_stream_async_reg #(.width_p(stream_data_width_p)) data_reg (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .en_i(data_en), .data_i(bus.stream_data_i), .data_o(data_r)
  );

  bp_stream_async_reg #(.width_p(stream_data_width_p)) resp_reg (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .en_i(resp_en), .data_i(resp_d), .data_o(resp_r)
  );

endmodule

// File: tb/tb_bp_stream_axil_master.sv
// Testbench for bp_stream_axil_master: directed host commands, a reactive
// AXI-Lite slave with configurable AW/W wait states, and a scoreboard monitor
// that checks every AXI and response-stream handshake against queued
// expectations. Honours BP_STREAM_AXIL_WRITE_ACK_EN the same way as the RTL.
module tb_bp_stream_axil_master;
  import bp_me_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bp_stream_axil_master_if bus ();

  bp_stream_axil_master dut (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .bus      (bus)
  );

  int tests = 0;
  int errors = 0;

  logic [31:0] exp_resp_q[$];
  logic [31:0] exp_aw_q[$];
  logic [31:0] exp_w_q[$];
  logic [31:0] exp_ar_q[$];
  int b_count = 0;
  int exp_b_count = 0;

  int aw_delay = 0;
  int w_delay = 0;
  logic [1:0]  cfg_bresp = 2'b00;
  logic [31:0] cfg_rdata = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    errors++;
    $display("FAIL %s: got event, expected none", name);
  endtask

  // Reactive AXI-Lite slave
  initial begin
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs, got_aw, got_w;
    int aw_cnt, w_cnt;
    got_aw = 0; got_w = 0; aw_cnt = 0; w_cnt = 0;
    bus.m_axil_awready_i = 0; bus.m_axil_wready_i = 0;
    bus.m_axil_bvalid_i = 0;  bus.m_axil_bresp_i = 0;
    bus.m_axil_arready_i = 0; bus.m_axil_rvalid_i = 0;
    bus.m_axil_rdata_i = 0;   bus.m_axil_rresp_i = 0;
    forever begin
      @(negedge clk);
      aw_hs = bus.m_axil_awvalid_o && bus.m_axil_awready_i;
      w_hs  = bus.m_axil_wvalid_o  && bus.m_axil_wready_i;
      b_hs  = bus.m_axil_bvalid_i  && bus.m_axil_bready_o;
      ar_hs = bus.m_axil_arvalid_o && bus.m_axil_arready_i;
      r_hs  = bus.m_axil_rvalid_i  && bus.m_axil_rready_o;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        got_aw = 0; got_w = 0; aw_cnt = 0; w_cnt = 0;
        bus.m_axil_awready_i = 0; bus.m_axil_wready_i = 0;
        bus.m_axil_bvalid_i = 0;  bus.m_axil_arready_i = 0; bus.m_axil_rvalid_i = 0;
      end else begin
        if (aw_hs) got_aw = 1;
        if (w_hs)  got_w = 1;
        if (b_hs)  bus.m_axil_bvalid_i = 0;
        if (got_aw && got_w) begin
          bus.m_axil_bvalid_i = 1;
          bus.m_axil_bresp_i  = cfg_bresp;
          got_aw = 0;
          got_w  = 0;
        end
        if (r_hs) bus.m_axil_rvalid_i = 0;
        if (ar_hs) begin
          bus.m_axil_rvalid_i = 1;
          bus.m_axil_rdata_i  = cfg_rdata;
          bus.m_axil_rresp_i  = 2'b01;
        end
        if (bus.m_axil_awvalid_o) begin
          bus.m_axil_awready_i = (aw_cnt >= aw_delay);
          aw_cnt++;
        end else begin
          bus.m_axil_awready_i = 0;
          aw_cnt = 0;
        end
        if (bus.m_axil_wvalid_o) begin
          bus.m_axil_wready_i = (w_cnt >= w_delay);
          w_cnt++;
        end else begin
          bus.m_axil_wready_i = 0;
          w_cnt = 0;
        end
        bus.m_axil_arready_i = bus.m_axil_arvalid_o;
      end
    end
  end

  // Scoreboard monitor: handshakes and valid/payload stability
  initial begin
    logic pend_aw, pend_w, pend_ar, pend_s;
    logic [31:0] hold_aw, hold_w, hold_ar, hold_s;
    pend_aw = 0; pend_w = 0; pend_ar = 0; pend_s = 0;
    hold_aw = 0; hold_w = 0; hold_ar = 0; hold_s = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend_aw = 0; pend_w = 0; pend_ar = 0; pend_s = 0;
        continue;
      end
      if (pend_aw) chk("aw_hold", {31'b0, bus.m_axil_awvalid_o, bus.m_axil_awaddr_o}, {32'd1, hold_aw});
      if (pend_w)  chk("w_hold",  {31'b0, bus.m_axil_wvalid_o,  bus.m_axil_wdata_o},  {32'd1, hold_w});
      if (pend_ar) chk("ar_hold", {31'b0, bus.m_axil_arvalid_o, bus.m_axil_araddr_o}, {32'd1, hold_ar});
      if (pend_s)  chk("resp_hold", {31'b0, bus.stream_v_o, bus.stream_data_o}, {32'd1, hold_s});
      if (bus.stream_v_o) chk("ready_o_in_resp", bus.stream_ready_o, 0);

      if (bus.m_axil_awvalid_o && bus.m_axil_awready_i) begin
        if (exp_aw_q.size() == 0) fail_now("aw_unexpected");
        else chk("awaddr", bus.m_axil_awaddr_o, exp_aw_q.pop_front());
        chk("awprot", bus.m_axil_awprot_o, 3'b000);
      end
      if (bus.m_axil_wvalid_o && bus.m_axil_wready_i) begin
        if (exp_w_q.size() == 0) fail_now("w_unexpected");
        else chk("wdata", bus.m_axil_wdata_o, exp_w_q.pop_front());
        chk("wstrb", bus.m_axil_wstrb_o, 4'hF);
      end
      if (bus.m_axil_arvalid_o && bus.m_axil_arready_i) begin
        if (exp_ar_q.size() == 0) fail_now("ar_unexpected");
        else chk("araddr", bus.m_axil_araddr_o, exp_ar_q.pop_front());
        chk("arprot", bus.m_axil_arprot_o, 3'b000);
      end
      if (bus.m_axil_bvalid_i && bus.m_axil_bready_o) b_count++;
      if (bus.stream_v_o && bus.stream_ready_i) begin
        if (exp_resp_q.size() == 0) fail_now("resp_unexpected");
        else chk("resp_data", bus.stream_data_o, exp_resp_q.pop_front());
      end

      pend_aw = bus.m_axil_awvalid_o && !bus.m_axil_awready_i; hold_aw = bus.m_axil_awaddr_o;
      pend_w  = bus.m_axil_wvalid_o  && !bus.m_axil_wready_i;  hold_w  = bus.m_axil_wdata_o;
      pend_ar = bus.m_axil_arvalid_o && !bus.m_axil_arready_i; hold_ar = bus.m_axil_araddr_o;
      pend_s  = bus.stream_v_o && !bus.stream_ready_i;         hold_s  = bus.stream_data_o;
    end
  end

  // Present one beat; returns one cycle after it is accepted (posedge + 1)
  task automatic send_beat(input logic [31:0] d);
    int n;
    n = 0;
    bus.stream_v_i = 1;
    bus.stream_data_i = d;
    forever begin
      @(negedge clk);
      if (bus.stream_ready_o) break;
      n++;
      if (n > 200) begin
        chk("beat_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.stream_v_i = 0;
  endtask

  task automatic write_cmd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] br);
    cfg_bresp = br;
    exp_aw_q.push_back({a[31:2], 2'b00});
    exp_w_q.push_back(d);
    exp_b_count++;
`ifdef BP_STREAM_AXIL_WRITE_ACK_EN
    exp_resp_q.push_back({30'b0, br});
`endif
    send_beat(a);
    send_beat(d);
  endtask

  task automatic read_cmd(input logic [31:0] a, input logic [31:0] rd);
    cfg_rdata = rd;
    exp_ar_q.push_back({a[31:2], 2'b00});
    exp_resp_q.push_back(rd);
    send_beat(a);
    send_beat(32'h0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!bus.stream_ready_o) begin
      @(posedge clk);
      #1;
      n++;
      if (n > 200) begin
        chk("idle_timeout", 1, 0);
        break;
      end
    end
  endtask

  // Directed stimulus
  initial begin
    bus.stream_v_i = 0;
    bus.stream_data_i = 0;
    bus.stream_ready_i = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stream_ready_o", bus.stream_ready_o, 1);
    chk("rst_stream_v_o", bus.stream_v_o, 0);
    chk("rst_valids", {bus.m_axil_awvalid_o, bus.m_axil_wvalid_o, bus.m_axil_arvalid_o}, 3'b000);
    chk("rst_readies", {bus.m_axil_bready_o, bus.m_axil_rready_o}, 2'b00);
    chk("rst_awaddr", bus.m_axil_awaddr_o, 0);
    chk("rst_wdata", bus.m_axil_wdata_o, 0);
    chk("rst_resp", bus.stream_data_o, 0);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Zero-wait write and its cycle timing
    write_cmd(32'h8000_1001, 32'hDEAD_BEEF, axil_resp_okay_gp);
    chk("wr_awvalid_n1", bus.m_axil_awvalid_o, 1);
    chk("wr_wvalid_n1", bus.m_axil_wvalid_o, 1);
    @(posedge clk); #1;
    chk("wr_bready_n2", bus.m_axil_bready_o, 1);
    @(posedge clk); #1;
`ifdef BP_STREAM_AXIL_WRITE_ACK_EN
    chk("wr_ack_n3", bus.stream_v_o, 1);
`else
    chk("wr_idle_n3", {bus.stream_ready_o, bus.stream_v_o}, 2'b10);
`endif
    wait_idle();

    // Zero-wait read and its cycle timing
    read_cmd(32'h0000_2000, 32'h1234_5678);
    chk("rd_arvalid_n1", bus.m_axil_arvalid_o, 1);
    @(posedge clk); #1;
    chk("rd_rready_n2", bus.m_axil_rready_o, 1);
    @(posedge clk); #1;
    chk("rd_v_o_n3", bus.stream_v_o, 1);
    wait_idle();

    // Reserved bit 1 must not reach the bus
    read_cmd(32'h0000_3002, 32'hCAFE_F00D);
    wait_idle();

    // AW late, W immediate
    aw_delay = 3;
    write_cmd(32'h4000_0005, 32'h1111_2222, axil_resp_okay_gp);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("aw_late_valids", {bus.m_axil_awvalid_o, bus.m_axil_wvalid_o}, 2'b10);
    wait_idle();
    aw_delay = 0;

    // W late, AW immediate
    w_delay = 3;
    write_cmd(32'h4000_0009, 32'h3333_4444, axil_resp_okay_gp);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("w_late_valids", {bus.m_axil_awvalid_o, bus.m_axil_wvalid_o}, 2'b01);
    wait_idle();
    w_delay = 0;

    // Backpressure on the response stream
    bus.stream_ready_i = 0;
    read_cmd(32'h0000_5000, 32'hA5A5_5A5A);
    for (int i = 0; i < 20 && !bus.stream_v_o; i++) begin
      @(posedge clk); #1;
    end
    chk("bp_v_o", bus.stream_v_o, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_ready_o_low", bus.stream_ready_o, 0);
      chk("bp_data_stable", bus.stream_data_o, 32'hA5A5_5A5A);
    end
    bus.stream_ready_i = 1;
    wait_idle();
    read_cmd(32'h0000_5004, 32'h0F0F_0F0F);
    wait_idle();

    // Error response on a write
    write_cmd(32'h6000_0001, 32'h0000_0000, axil_resp_slverr_gp);
    wait_idle();

    // Reset while AW/W are pending
    aw_delay = 10;
    w_delay = 10;
    write_cmd(32'h7000_0001, 32'h0000_0055, axil_resp_okay_gp);
    @(posedge clk); #1;
    chk("pre_rst_awvalid", bus.m_axil_awvalid_o, 1);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("rst_mid_valids", {bus.m_axil_awvalid_o, bus.m_axil_wvalid_o}, 2'b00);
    chk("rst_mid_ready_o", bus.stream_ready_o, 1);
    exp_aw_q.delete();
    exp_w_q.delete();
    exp_resp_q.delete();
    exp_b_count--;
    aw_delay = 0;
    w_delay = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk); #1;
    read_cmd(32'h0000_8000, 32'h0BAD_CAFE);
    wait_idle();
    write_cmd(32'h9000_0001, 32'h0000_0077, axil_resp_okay_gp);
    wait_idle();

    repeat (5) @(posedge clk);
    #1;
    chk("left_resp", exp_resp_q.size(), 0);
    chk("left_aw", exp_aw_q.size(), 0);
    chk("left_w", exp_w_q.size(), 0);
    chk("left_ar", exp_ar_q.size(), 0);
    chk("b_count", b_count, exp_b_count);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
